// File: rtl/wb_mem_arbiter_if.sv
// Wishbone point-to-point bus bundle shared by the arbiter's master-facing and slave-facing ports.
// The arbiter takes the slave modport on each requester side and the master modport toward memory.
interface wb_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        width;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              err;

    modport master (
        output cyc, stb, we, addr, wdata, width,
        input  rdata, ack, err
    );

    modport slave (
        input  cyc, stb, we, addr, wdata, width,
        output rdata, ack, err
    );

endinterface

// File: rtl/wb_mem_arbiter.sv
// Two-master round-robin Wishbone arbiter (m0 = fetch, m1 = data) in front of one memory port.
// Define WB_ARB_TIMEOUT_EN to abort granted beats that wait TIMEOUT cycles for ack.
module wb_mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   iClk,
    input  logic                   nRst,
    wb_mem_arbiter_if.slave        m0,
    wb_mem_arbiter_if.slave        m1,
    wb_mem_arbiter_if.master       s,
    output logic [1:0]             oGrant
);

    // Encoding doubles as the one-hot grant vector {m1,m0}.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StG0   = 2'b01,
        StG1   = 2'b10
    } state_e;

    state_e state_q;
    logic   last_q;  // 0: m0 completed last, 1: m1 completed last
    logic   req0;
    logic   req1;
    logic   own_req;
    logic   owner;
    logic   tmo;

    assign req0  = m0.cyc & m0.stb;
    assign req1  = m1.cyc & m1.stb;
    assign owner = (state_q == StG1);

    always_comb begin
        own_req = 1'b0;
        unique case (state_q)
            StG0:    own_req = req0;
            StG1:    own_req = req1;
            default: own_req = 1'b0;
        endcase
    end

    // On contention the master that did not finish last wins.
    function automatic state_e pick(input logic r0, input logic r1, input logic lst);
        state_e nxt;
        if (r0 && r1) begin
            nxt = lst ? StG0 : StG1;
        end else if (r0) begin
            nxt = StG0;
        end else if (r1) begin
            nxt = StG1;
        end else begin
            nxt = StIdle;
        end
        return nxt;
    endfunction

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] tmo_cnt_q;

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            tmo_cnt_q <= '0;
        end else if (state_q == StIdle || s.ack || tmo) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign tmo = (state_q != StIdle) && (tmo_cnt_q == CNT_W'(TIMEOUT));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state_q <= StIdle;
            last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q <= pick(req0, req1, last_q);
                end
                StG0, StG1: begin
                    if (tmo || s.ack) begin
                        last_q  <= owner;
                        state_q <= pick(req0, req1, owner);
                    end else if (!own_req) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign oGrant = state_q;

    // Slave mux and ack/err steering follow the registered grant only.
    always_comb begin
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = 1'b0;
        s.addr   = '0;
        s.wdata  = '0;
        s.width  = 2'b00;
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        m0.rdata = s.rdata;
        m1.rdata = s.rdata;
        unique case (state_q)
            StG0: begin
                s.cyc   = m0.cyc & ~tmo;
                s.stb   = m0.stb & ~tmo;
                s.we    = m0.we;
                s.addr  = m0.addr;
                s.wdata = m0.wdata;
                s.width = m0.width;
                m0.ack  = s.ack & ~tmo;
                m0.err  = tmo;
            end
            StG1: begin
                s.cyc   = m1.cyc & ~tmo;
                s.stb   = m1.stb & ~tmo;
                s.we    = m1.we;
                s.addr  = m1.addr;
                s.wdata = m1.wdata;
                s.width = m1.width;
                m1.ack  = s.ack & ~tmo;
                m1.err  = tmo;
            end
            default: begin
            end
        endcase
    end

endmodule
